hdlc_rx_monitor: RTL and testbench

Synthesizable, parametrised protocol checker for the HDLC receive path. It observes the serial Rx line and the Rx status strobes, and checks four timing rules at run time: flag detect, abort signal, end of frame and overflow. It reports violations as per-check pulses, sticky flags and a saturating error counter. It sits beside the HDLC Rx module in the design and in the test_hdlc bench, and can stay in silicon as a built-in self-check.

---
 rtl/hdlc_rx_monitor_if.sv | 31 +++
 rtl/hdlc_rx_monitor.sv | 106 ++++++++++
 tb/tb_hdlc_rx_monitor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_monitor_if.sv
// Signal bundle between the HDLC Rx path and its run-time protocol monitor.
// The master side owns the observed strobes and controls; the slave side reports errors.
interface hdlc_rx_monitor_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             Rx;
  logic             Rx_FlagDetect;
  logic             Rx_AbortDetect;
  logic             Rx_AbortSignal;
  logic             Rx_ValidFrame;
  logic             Rx_EoF;
  logic             Rx_NewByte;
  logic             Rx_Overflow;
  logic [3:0]       CheckEn;
  logic             ClrErr;
  logic [3:0]       ErrPulse;
  logic [3:0]       ErrSticky;
  logic [CNT_W-1:0] ErrCnt;

  modport master (
    output Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_NewByte, Rx_Overflow, CheckEn, ClrErr,
    input  ErrPulse, ErrSticky, ErrCnt
  );

  modport slave (
    input  Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_NewByte, Rx_Overflow, CheckEn, ClrErr,
    output ErrPulse, ErrSticky, ErrCnt
  );
endinterface

// File: rtl/hdlc_rx_monitor.sv
// Passive run-time checker for the HDLC Rx path: flag detect, abort, end-of-frame and
// overflow timing. Violations give per-check pulses, sticky flags and a saturating count.
module hdlc_rx_monitor #(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned OVF_LAT   = 1,
  parameter int unsigned CNT_W     = 16
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_rx_monitor_if.slave mon
);

  localparam int unsigned BW = $clog2(MAX_BYTES + 2);
  localparam logic [BW-1:0] OvfCount = BW'(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [7:0]          srQ, srD;
  logic [FLAG_LAT-1:0] flagPipeQ, flagPipeD;
  logic [FLAG_LAT:0]   flagShift;
  logic [OVF_LAT-1:0]  ovfPipeQ, ovfPipeD;
  logic [OVF_LAT:0]    ovfShift;
  logic                prevValidQ;
  logic                abortPendQ, abortPendD;
  logic                eofPendQ, eofPendD;
  logic [BW-1:0]       byteCntQ, byteCntD;
  logic                ovfArm;
  logic [3:0]          viol;
  logic [3:0]          pulseQ;
  logic [3:0]          stickyQ, stickyD;
  logic [CNT_W-1:0]    cntQ, cntD;
  logic [CNT_W+2:0]    cntSum;

  always_comb begin
    srD = {srQ[6:0], mon.Rx};

    // The flag expectation is keyed on the shift register value after this edge.
    flagShift = {flagPipeQ, srD == 8'b0111_1110};
    flagPipeD = flagShift[FLAG_LAT-1:0];

    abortPendD = mon.Rx_AbortDetect & mon.Rx_ValidFrame;
    eofPendD   = prevValidQ & ~mon.Rx_ValidFrame;

    byteCntD = byteCntQ;
    ovfArm   = 1'b0;
    if (mon.Rx_ValidFrame && !prevValidQ) begin
      byteCntD = '0;
    end
    // Saturating at MAX_BYTES+1 limits overflow expectations to one per frame.
    if (mon.Rx_NewByte && mon.Rx_ValidFrame && (byteCntD != OvfCount)) begin
      byteCntD = byteCntD + BW'(1);
      ovfArm   = (byteCntD == OvfCount);
    end
    ovfShift = {ovfPipeQ, ovfArm};
    ovfPipeD = ovfShift[OVF_LAT-1:0];

    viol[0] = flagPipeQ[FLAG_LAT-1] & ~mon.Rx_FlagDetect;
    viol[1] = abortPendQ & ~mon.Rx_AbortSignal;
    viol[2] = eofPendQ & ~mon.Rx_EoF;
    viol[3] = ovfPipeQ[OVF_LAT-1] & ~mon.Rx_Overflow;
    viol    = viol & mon.CheckEn;

    cntSum = {3'b000, cntQ} + (CNT_W+3)'(viol[0]) + (CNT_W+3)'(viol[1])
           + (CNT_W+3)'(viol[2]) + (CNT_W+3)'(viol[3]);

    // A clear in the same cycle as a violation wins over latching and counting it.
    if (mon.ClrErr) begin
      stickyD = '0;
      cntD    = '0;
    end else begin
      stickyD = stickyQ | viol;
      cntD    = (cntSum > {3'b000, CntMax}) ? CntMax : cntSum[CNT_W-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      srQ        <= 8'hFF;
      flagPipeQ  <= '0;
      ovfPipeQ   <= '0;
      prevValidQ <= 1'b0;
      abortPendQ <= 1'b0;
      eofPendQ   <= 1'b0;
      byteCntQ   <= '0;
      pulseQ     <= '0;
      stickyQ    <= '0;
      cntQ       <= '0;
    end else begin
      srQ        <= srD;
      flagPipeQ  <= flagPipeD;
      ovfPipeQ   <= ovfPipeD;
      prevValidQ <= mon.Rx_ValidFrame;
      abortPendQ <= abortPendD;
      eofPendQ   <= eofPendD;
      byteCntQ   <= byteCntD;
      pulseQ     <= viol;
      stickyQ    <= stickyD;
      cntQ       <= cntD;
    end
  end

  assign mon.ErrPulse  = pulseQ;
  assign mon.ErrSticky = stickyQ;
  assign mon.ErrCnt    = cntQ;

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Directed bench for hdlc_rx_monitor: expected ErrPulse values are queued with their due
// cycle when stimulus is driven and checked as each cycle completes.
module tb_hdlc_rx_monitor;

  localparam int unsigned CntW = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  hdlc_rx_monitor_if #(.CNT_W(CntW)) bus ();

  hdlc_rx_monitor #(
    .FLAG_LAT (2),
    .MAX_BYTES(128),
    .OVF_LAT  (1),
    .CNT_W    (CntW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .mon(bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
  } exp_t;

  exp_t expQ[$];
  int   nAsserts = 0;
  int   nFail    = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    nAsserts++;
    assert (obs === req) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  task automatic expectPulse(input int ofs, input logic [3:0] p);
    exp_t e;
    e.cyc   = cyc + ofs;
    e.pulse = p;
    expQ.push_back(e);
  endtask

  // One clock; ErrPulse must match a queued expectation due now, or be idle.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    cyc++;
    if (expQ.size() != 0 && expQ[0].cyc == cyc) begin
      e = expQ.pop_front();
      chk("ErrPulse", 16'(bus.ErrPulse), 16'(e.pulse));
    end else begin
      chk("ErrPulseIdle", 16'(bus.ErrPulse), 16'h0000);
    end
  endtask

  task automatic sendFlag();
    logic [7:0] pat;
    pat = 8'b0111_1110;
    for (int i = 7; i >= 0; i--) begin
      bus.Rx = pat[i];
      tick();
    end
    bus.Rx = 1'b1;
  endtask

  task automatic chkErr(input string tag, input int cnt, input logic [3:0] sticky);
    chk({tag, "_ErrCnt"}, 16'(bus.ErrCnt), 16'(cnt));
    chk({tag, "_ErrSticky"}, 16'(bus.ErrSticky), 16'(sticky));
  endtask

  initial begin
    bus.Rx             = 1'b1;
    bus.Rx_FlagDetect  = 1'b0;
    bus.Rx_AbortDetect = 1'b0;
    bus.Rx_AbortSignal = 1'b0;
    bus.Rx_ValidFrame  = 1'b0;
    bus.Rx_EoF         = 1'b0;
    bus.Rx_NewByte     = 1'b0;
    bus.Rx_Overflow    = 1'b0;
    bus.CheckEn        = 4'hF;
    bus.ClrErr         = 1'b0;

    // Reset state.
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    chkErr("reset", 0, 4'b0000);
    repeat (8) tick();

    // FLAG: strobe exactly on time.
    sendFlag();
    tick();
    bus.Rx_FlagDetect = 1'b1;
    tick();
    bus.Rx_FlagDetect = 1'b0;
    tick();
    chkErr("flagOnTime", 0, 4'b0000);

    // FLAG: strobe one edge late.
    sendFlag();
    expectPulse(2, 4'b0001);
    tick();
    tick();
    bus.Rx_FlagDetect = 1'b1;
    tick();
    bus.Rx_FlagDetect = 1'b0;
    tick();
    chkErr("flagLate", 1, 4'b0001);

    // ABORT: missing Rx_AbortSignal, enabled then masked.
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b1;
    expectPulse(2, 4'b0010);
    tick();
    bus.Rx_AbortDetect = 1'b0;
    tick();
    chkErr("abort", 2, 4'b0011);
    bus.CheckEn = 4'b1101;
    bus.Rx_AbortDetect = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    tick();
    bus.CheckEn = 4'hF;
    tick();
    chkErr("abortMasked", 2, 4'b0011);

    // EOF missing on the same edge as a late FLAG: two-bit pulse, count +2.
    sendFlag();
    bus.Rx_ValidFrame = 1'b0;
    expectPulse(2, 4'b0101);
    tick();
    tick();
    tick();
    chkErr("eofFlag", 4, 4'b0111);

    // OVF: 129 bytes with Rx_Overflow stuck low.
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_NewByte = 1'b1;
    repeat (128) tick();
    expectPulse(2, 4'b1000);
    tick();
    bus.Rx_NewByte = 1'b0;
    tick();
    bus.Rx_ValidFrame = 1'b0;
    tick();
    bus.Rx_EoF = 1'b1;
    tick();
    bus.Rx_EoF = 1'b0;
    tick();
    chkErr("ovf129", 5, 4'b1111);

    // OVF: exactly MAX_BYTES is legal.
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_NewByte = 1'b1;
    repeat (128) tick();
    bus.Rx_NewByte = 1'b0;
    tick();
    tick();
    bus.Rx_ValidFrame = 1'b0;
    tick();
    bus.Rx_EoF = 1'b1;
    tick();
    bus.Rx_EoF = 1'b0;
    tick();
    chkErr("ovf128", 5, 4'b1111);

    // Saturation: clear, preload 14 abort errors, then three simultaneous violations.
    bus.ClrErr = 1'b1;
    tick();
    bus.ClrErr = 1'b0;
    chkErr("clear1", 0, 4'b0000);
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b1;
    for (int k = 2; k <= 15; k++) expectPulse(k, 4'b0010);
    repeat (14) tick();
    bus.Rx_AbortDetect = 1'b0;
    tick();
    chkErr("preload", 14, 4'b0010);
    bus.Rx_NewByte = 1'b1;
    repeat (128) tick();
    bus.Rx_NewByte = 1'b0;
    sendFlag();
    bus.Rx_NewByte     = 1'b1;
    bus.Rx_AbortDetect = 1'b1;
    expectPulse(2, 4'b1011);
    tick();
    bus.Rx_NewByte     = 1'b0;
    bus.Rx_AbortDetect = 1'b0;
    tick();
    chkErr("saturate", 15, 4'b1011);
    bus.Rx_AbortDetect = 1'b1;
    expectPulse(2, 4'b0010);
    tick();
    bus.Rx_AbortDetect = 1'b0;
    tick();
    chkErr("satHold", 15, 4'b1011);

    // Clear on the same edge as a violation: pulse still seen, nothing latched.
    bus.Rx_AbortDetect = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    bus.ClrErr = 1'b1;
    expectPulse(1, 4'b0010);
    tick();
    bus.ClrErr = 1'b0;
    chkErr("clearWins", 0, 4'b0000);
    bus.Rx_ValidFrame = 1'b0;
    tick();
    bus.Rx_EoF = 1'b1;
    tick();
    bus.Rx_EoF = 1'b0;
    tick();

    // Reset discards a pending FLAG expectation and clears error state.
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b1;
    expectPulse(2, 4'b0010);
    tick();
    bus.Rx_AbortDetect = 1'b0;
    tick();
    bus.Rx_ValidFrame = 1'b0;
    tick();
    bus.Rx_EoF = 1'b1;
    tick();
    bus.Rx_EoF = 1'b0;
    chkErr("preReset", 1, 4'b0010);
    sendFlag();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    repeat (4) tick();
    chkErr("midReset", 0, 4'b0000);

    chk("expectQueueDrained", 16'(expQ.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
